// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, baud counter sizing and the
// default bit period used by both the transmitter and the future receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   // 50 MHz / 17778 baud
   localparam int UART_DEFAULT_CLKS_PER_BIT = 2813;

   function automatic int baud_cnt_width(input int clks_per_bit);
      return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal cycle.
// Held at zero while i_clear is high so a new bit period starts aligned.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (r_count == CNT_LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_tick = (r_count == CNT_LAST) && !i_clear;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready word handshake.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx
);

   localparam int BIT_W = 4;
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   generate
      if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
          (STOP_BITS != 1 && STOP_BITS != 2) ||
          (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
         $error("uart_tx_param: illegal parameter value");
      end
   endgenerate

   uart_state_t          r_state, w_state_next;
   logic [DATA_BITS-1:0] r_shift, w_shift_next;
   logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_next;
   logic                 r_tx, w_tx_next;
   logic                 w_tick;
   logic                 w_baud_clear;

`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_INIT = (PARITY_ODD != 0);
   logic r_parity, w_parity_next;
`endif

   // Counter is parked at zero in IDLE so START gets a full bit period.
   assign w_baud_clear = (r_state == IDLE);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk    (clk),
      .rst    (rst),
      .i_clear(w_baud_clear),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_next;
         r_shift   <= w_shift_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_tx      <= w_tx_next;
`ifdef UART_TX_PARITY_EN
         r_parity  <= w_parity_next;
`endif
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_shift_next   = r_shift;
      w_bit_cnt_next = r_bit_cnt;
      w_tx_next      = r_tx;
`ifdef UART_TX_PARITY_EN
      w_parity_next  = r_parity;
`endif
      case (r_state)
         IDLE: begin
            w_tx_next      = 1'b1;
            w_bit_cnt_next = '0;
            if (tx_valid) begin
               w_state_next = START;
               w_shift_next = tx_data;
               w_tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
               w_parity_next = (^tx_data) ^ PARITY_INIT;
`endif
            end
         end
         START: begin
            w_tx_next = 1'b0;
            if (w_tick) begin
               w_state_next = DATA;
               w_tx_next    = r_shift[0];
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit_cnt == DATA_LAST) begin
                  w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_next   = PARITY;
                  w_tx_next      = r_parity;
`else
                  w_state_next   = STOP;
                  w_tx_next      = 1'b1;
`endif
               end else begin
                  // Line already shows bit 0 of the shifter; pre-load the next one.
                  w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
                  w_shift_next   = r_shift >> 1;
                  w_tx_next      = r_shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_tick) begin
               w_state_next = STOP;
               w_tx_next    = 1'b1;
            end
         end
`endif
         STOP: begin
            w_tx_next = 1'b1;
            if (w_tick) begin
               if (r_bit_cnt == STOP_LAST) begin
                  w_state_next   = IDLE;
                  w_bit_cnt_next = '0;
               end else begin
                  w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
               end
            end
         end
         default: begin
            w_state_next   = IDLE;
            w_tx_next      = 1'b1;
            w_bit_cnt_next = '0;
         end
      endcase
   end

   assign tx_ready = (r_state == IDLE);
   assign tx_busy  = (r_state != IDLE);
   assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: an 8N1 instance and a 5-bit/2-stop
// instance, both at 4 clocks per bit.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int CPB  = 4;
   localparam int FR_A = (1 + 8 + P + 1) * CPB;
   localparam int NS_A = 10 + P;
   localparam int FR_B = (1 + 5 + P + 2) * CPB;
   localparam int NS_B = 8 + P;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a_data = 8'h00;
   logic       a_valid = 1'b0;
   logic       a_ready, a_busy, a_tx;
   logic [4:0] b_data = 5'h00;
   logic       b_valid = 1'b0;
   logic       b_ready, b_busy, b_tx;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
   ) dut_a (
      .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid),
      .tx_ready(a_ready), .tx_busy(a_busy), .tx(a_tx)
   );

   uart_tx_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)
   ) dut_b (
      .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid),
      .tx_ready(b_ready), .tx_busy(b_busy), .tx(b_tx)
   );

   // Expected line samples at bit centres, first sample in the MSB position.
   typedef struct {
      logic [7:0]  data;
      logic [10:0] exp_np;
      logic [10:0] exp_p;
      string       name;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_ready_a();
      int n;
      n = 0;
      @(negedge clk);
      while (!a_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("a_ready_wait", 32'(a_ready), 32'd1);
   endtask

   task automatic wait_ready_b();
      int n;
      n = 0;
      @(negedge clk);
      while (!b_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b_ready_wait", 32'(b_ready), 32'd1);
   endtask

   task automatic run_frame(input logic [7:0] d, input logic [10:0] exp,
                            input bit disturb, input string nm);
      logic [10:0] got;
      int low_cnt, idle_bad;
      got = '0;
      low_cnt = 0;
      wait_ready_a();
      a_data  = d;
      a_valid = 1'b1;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      for (int c = 0; c < FR_A; c++) begin
         @(negedge clk);
         if (!a_ready && a_busy) low_cnt++;
         if (c % CPB == 2) got[NS_A - 1 - c / CPB] = a_tx;
         if (disturb) begin
            if (c < FR_A - 8) begin
               a_valid = c[0];
               a_data  = 8'($urandom);
            end else begin
               a_valid = 1'b0;
            end
         end
      end
      @(negedge clk);
      $display("frame %s data=0x%02h bits=%b", nm, d, got);
      check({nm, "_bits"}, 32'(got), 32'(exp));
      check({nm, "_busy_cycles"}, 32'(low_cnt), 32'(FR_A));
      check({nm, "_ready_after"}, 32'(a_ready), 32'd1);
      check({nm, "_tx_after"}, 32'(a_tx), 32'd1);
      if (disturb) begin
         idle_bad = 0;
         for (int c = 0; c < 2 * FR_A; c++) begin
            @(negedge clk);
            if (!a_ready || !a_tx) idle_bad++;
         end
         check({nm, "_no_extra_frame"}, 32'(idle_bad), 32'd0);
      end
   endtask

   initial begin
      logic        rdy_hist[128];
      logic        tx_hist[128];
      logic [10:0] got;
      logic [10:0] exp;
      int          r, low_cnt, hi_stop, base;

      vecs[0] = '{8'hA5, 11'b0101001011, 11'b01010010101, "a5"};
      vecs[1] = '{8'h07, 11'b0111000001, 11'b01110000011, "07"};
      vecs[2] = '{8'h00, 11'b0000000001, 11'b00000000001, "00"};
      vecs[3] = '{8'hFF, 11'b0111111111, 11'b01111111101, "ff"};
      vecs[4] = '{8'h80, 11'b0000000011, 11'b00000000111, "80"};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx", 32'(a_tx), 32'd1);
      check("rst_ready", 32'(a_ready), 32'd1);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_b_tx", 32'(b_tx), 32'd1);
      check("rst_b_ready", 32'(b_ready), 32'd1);
      rst = 1'b0;

      // Table-driven frames
      foreach (vecs[i]) begin
`ifdef UART_TX_PARITY_EN
         run_frame(vecs[i].data, vecs[i].exp_p, 1'b0, vecs[i].name);
`else
         run_frame(vecs[i].data, vecs[i].exp_np, 1'b0, vecs[i].name);
`endif
      end

      // Inputs wiggling while busy: 0x3C must go out untouched, nothing queued
`ifdef UART_TX_PARITY_EN
      run_frame(8'h3C, 11'b00011110001, 1'b1, "busy_inputs");
`else
      run_frame(8'h3C, 11'b0001111001, 1'b1, "busy_inputs");
`endif

      // Back-to-back with tx_valid held: 0x55 then 0xAA
      wait_ready_a();
      a_data  = 8'h55;
      a_valid = 1'b1;
      @(posedge clk);
      #1;
      a_data = 8'hAA;
      for (int c = 0; c <= 2 * FR_A + 1; c++) begin
         @(negedge clk);
         rdy_hist[c] = a_ready;
         tx_hist[c]  = a_tx;
         if (c == FR_A + 5) a_valid = 1'b0;
      end
      r = -1;
      low_cnt = 0;
      for (int c = 0; c <= 2 * FR_A; c++) begin
         if (rdy_hist[c]) begin
            low_cnt++;
            if (r < 0) r = c;
         end
      end
      check("b2b_ready_pulses", 32'(low_cnt), 32'd1);
      check("b2b_period", 32'(r + 1), 32'(FR_A + 1));
      if (r < 0) r = 0;
      check("b2b_gap_tx_high", 32'(tx_hist[r]), 32'd1);
      got = '0;
      for (int k = 0; k < NS_A; k++) got[NS_A - 1 - k] = tx_hist[k * CPB + 2];
`ifdef UART_TX_PARITY_EN
      exp = 11'b01010101001;
`else
      exp = 11'b0101010101;
`endif
      $display("frame b2b_first data=0x55 bits=%b", got);
      check("b2b_first_bits", 32'(got), 32'(exp));
      got = '0;
      for (int k = 0; k < NS_A; k++) got[NS_A - 1 - k] = tx_hist[r + 1 + k * CPB + 2];
`ifdef UART_TX_PARITY_EN
      exp = 11'b00101010101;
`else
      exp = 11'b0010101011;
`endif
      $display("frame b2b_second data=0xaa bits=%b", got);
      check("b2b_second_bits", 32'(got), 32'(exp));
      check("b2b_no_third", 32'(rdy_hist[2 * FR_A + 1]), 32'd1);

      // Reset during data bit 3 of a 0x00 frame
      wait_ready_a();
      a_data  = 8'h00;
      a_valid = 1'b1;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      for (int c = 0; c <= 4 * CPB + 1; c++) @(negedge clk);
      check("midrst_before_tx", 32'(a_tx), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      $display("abort frame data=0x00 at data bit 3");
      check("midrst_tx", 32'(a_tx), 32'd1);
      check("midrst_ready", 32'(a_ready), 32'd1);
      check("midrst_busy", 32'(a_busy), 32'd0);
      rst = 1'b0;
`ifdef UART_TX_PARITY_EN
      run_frame(8'hA5, 11'b01010010101, 1'b0, "after_rst");
`else
      run_frame(8'hA5, 11'b0101001011, 1'b0, "after_rst");
`endif

      // Reset beats a simultaneous accept
      wait_ready_a();
      a_data  = 8'hC3;
      a_valid = 1'b1;
      rst     = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      a_valid = 1'b0;
      $display("accept under reset data=0xc3");
      check("rst_vs_accept_ready", 32'(a_ready), 32'd1);
      check("rst_vs_accept_tx", 32'(a_tx), 32'd1);
      @(negedge clk);
      check("rst_vs_accept_idle", 32'(a_ready), 32'd1);

      // 5 data bits, 2 stop bits: 0x1F
      wait_ready_b();
      b_data  = 5'h1F;
      b_valid = 1'b1;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      b_data  = 5'h00;
      got = '0;
      low_cnt = 0;
      hi_stop = 0;
      base = FR_B - 2 * CPB;
      for (int c = 0; c < FR_B; c++) begin
         @(negedge clk);
         if (!b_ready) low_cnt++;
         if (c % CPB == 2) got[NS_B - 1 - c / CPB] = b_tx;
         if (c >= base && b_tx) hi_stop++;
      end
      @(negedge clk);
`ifdef UART_TX_PARITY_EN
      exp = 11'b011111011;
`else
      exp = 11'b01111111;
`endif
      $display("frame w5s2 data=0x1f bits=%b", got);
      check("w5s2_bits", 32'(got), 32'(exp));
      check("w5s2_busy_cycles", 32'(low_cnt), 32'(FR_B));
      check("w5s2_stop_high", 32'(hi_stop), 32'(2 * CPB));
      check("w5s2_ready_after", 32'(b_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter; next generation of the fixed 8N1 transmitter.
- Configurable baud divisor, data width and stop-bit count, with a valid/ready byte handshake and a busy flag.
- Optional parity generation.
- Sits between a byte producer (CPU bus bridge / debug streamer) and the board TX pin.

Parameters:
- CLKS_PER_BIT, 2813: clock cycles per serial bit (e.g. 2813 ≈ 50 MHz / 17778 baud); legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0: parity sense when parity is compiled in; 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  DATA_BITS  word to send, sampled only at handshake
- tx_valid  in  1  producer has a word
- tx_ready  out  1  block can accept a word (high exactly in IDLE)
- tx_busy  out  1  frame in progress (high in any state other than IDLE)
- tx  out  1  serial line, idle high

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE; tx = 1; tx_ready = 1; tx_busy = 0; baud and bit counters = 0.
- Output timing: tx_ready and tx_busy are decoded directly from the state register, with no combinational path from tx_valid. tx is a registered output.
- Handshake: a word is accepted on a rising edge where tx_valid && tx_ready.
  - tx_data is latched into a shift register at that edge.
  - Later changes to tx_data or tx_valid have no effect until tx_ready rises again.
  - tx_valid asserted while busy is ignored (not queued).
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Bit timing: each bit is held on tx for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Counter width is $clog2(CLKS_PER_BIT).
- IDLE: tx = 1. On accept, go to START; tx = 0 from the next cycle.
- START: one bit time low, then DATA.
- DATA: DATA_BITS bit times, LSB first. The bit counter runs 0..DATA_BITS-1.
  - On the last data bit's final cycle, go to PARITY if compiled in, else to STOP.
- STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Back-to-back: tx_ready rises the cycle after the last stop cycle. With tx_valid held high, the frame period is (1 + DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT + 1 cycles, where P = 1 with parity, else 0. No glitch on tx between frames; it stays high for that 1 idle cycle.
- Reset mid-frame: the frame is aborted. tx = 1 the cycle after rst is sampled high, and tx_ready = 1. No partial bit is completed.
- Reset wins over a simultaneous accept.
- Counters never exceed their terminal value. An unreachable state encoding returns to IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- Defined:
  - PARITY state inserted after DATA, lasting one bit time.
  - Bit value = XOR of the latched DATA_BITS data bits, XOR PARITY_ODD.
  - Frame grows by CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state and no parity logic.
  - PARITY_ODD is unused.

Decomposition:
- Package uart_pkg holds:
  - state typedef (IDLE, START, DATA, PARITY, STOP);
  - localparam helper for the baud counter width;
  - default CLKS_PER_BIT constant shared with the future receiver.
- One sub-module, uart_baud_tick: the CLKS_PER_BIT counter with clear and a one-cycle tick at the terminal count. It is reused by the receiver later.

Test Plan:
- Bench settings: CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, no parity. Send 0xA5 -> tx samples at bit centres 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). Each level lasts 4 cycles. tx_ready is low for 40 cycles.
- Parity: UART_TX_PARITY_EN defined, PARITY_ODD=0, send 0x07 -> parity bit 1 after data. With PARITY_ODD=1, parity bit 0. Frame is 44 cycles.
- Width and stop bits: DATA_BITS=5, STOP_BITS=2, send 0x1F (only the low 5 bits are used) -> start, five 1s, then 8 high stop cycles. Frame is 32 cycles.
- Back-to-back: tx_valid held high with 0x55 then 0xAA -> second start bit begins exactly 41 cycles after the first. tx_ready pulses high for 1 cycle between frames. The second frame carries 0xAA.
- Busy-time inputs: change tx_data and toggle tx_valid mid-frame -> transmitted bits are unchanged and no extra frame is sent.
- Reset mid-frame: assert rst during data bit 3 -> tx = 1 and tx_ready = 1 on the next cycle. A new accept afterwards produces a clean frame.
